// File: rtl/pixel_fifo_pkg.sv
// Shared definitions for the pixel gearbox FIFO.
// Default pixel width, lane extraction and geometry check.
package pixel_fifo_pkg;

  localparam int DEF_PIXEL_WIDTH = 8;
  localparam int MAX_WORD_BITS   = 512;
  localparam int MAX_PIXEL_BITS  = 64;

  // Lane 0 sits in the MSBs of the word.
  function automatic logic [MAX_PIXEL_BITS-1:0] lane_extract(
    input logic [MAX_WORD_BITS-1:0] word,
    input int                       lanes,
    input int                       width,
    input int                       lane
  );
    logic [MAX_WORD_BITS-1:0] sh;
    logic [MAX_WORD_BITS-1:0] mask;
    sh   = word >> ((lanes - 1 - lane) * width);
    mask = (MAX_WORD_BITS'(1) << width) - MAX_WORD_BITS'(1);
    return MAX_PIXEL_BITS'(sh & mask);
  endfunction

  // Read and write slots must fit side by side in the array.
  function automatic bit depth_ok(
    input int aw,
    input int wl,
    input int rl
  );
    return (1 << aw) >= (wl + rl);
  endfunction

endpackage

// File: rtl/pixel_lane_ram.sv
// Pixel register array with one write port per write lane
// and one combinational read port per read lane.
module pixel_lane_ram
  import pixel_fifo_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int WR_LANES    = 4,
  parameter int RD_LANES    = 3,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                                  clk,
  input  logic                                  we,
  input  logic [WR_LANES-1:0][ADDR_WIDTH-1:0]   wr_addr,
  input  logic [WR_LANES-1:0][PIXEL_WIDTH-1:0]  wr_data,
  input  logic [RD_LANES-1:0][ADDR_WIDTH-1:0]   rd_addr,
  output logic [RD_LANES-1:0][PIXEL_WIDTH-1:0]  rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [PIXEL_WIDTH-1:0] mem [DEPTH];

  // Lane addresses are distinct, so ports never collide.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < WR_LANES; k++) begin
        mem[wr_addr[k]] <= wr_data[k];
      end
    end
  end

  // Unregistered read of every read lane.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < RD_LANES; k++) begin
      rd_data[k] = mem[rd_addr[k]];
    end
  end

endmodule

// File: rtl/pixel_gearbox_fifo.sv
// Width-converting pixel FIFO: WR_LANES pixels in,
// RD_LANES pixels out, with flush and occupancy.
module pixel_gearbox_fifo
  import pixel_fifo_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int WR_LANES    = 4,
  parameter int RD_LANES    = 3,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WR_LANES*PIXEL_WIDTH-1:0] din,
  input  logic                            wr_req,
  output logic                            wr_vld,
  input  logic                            rd_req,
  output logic                            rd_vld,
  output logic [RD_LANES*PIXEL_WIDTH-1:0] dout,
  output logic                            dout_vld,
  input  logic                            flush,
  output logic [ADDR_WIDTH:0]             level
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;

  localparam logic [LW-1:0] WR_MAX = LW'(DEPTH - WR_LANES);
  localparam logic [LW-1:0] RD_MIN = LW'(RD_LANES);
  localparam logic [LW-1:0] WR_INC = LW'(WR_LANES);
  localparam logic [LW-1:0] RD_DEC = LW'(RD_LANES);

  localparam logic [ADDR_WIDTH-1:0] WR_STEP = ADDR_WIDTH'(WR_LANES);
  localparam logic [ADDR_WIDTH-1:0] RD_STEP = ADDR_WIDTH'(RD_LANES);

  if (!depth_ok(ADDR_WIDTH, WR_LANES, RD_LANES)) begin : g_depth_chk
    $error("pixel_gearbox_fifo: DEPTH must be >= WR_LANES + RD_LANES");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_en;
  logic                  rd_en;
  logic                  ram_we;
  logic [LW-1:0]         level_next;

  logic [WR_LANES-1:0][ADDR_WIDTH-1:0]  wr_addr;
  logic [WR_LANES-1:0][PIXEL_WIDTH-1:0] wr_data;
  logic [RD_LANES-1:0][ADDR_WIDTH-1:0]  rd_addr;
  logic [RD_LANES-1:0][PIXEL_WIDTH-1:0] rd_data;
  logic [RD_LANES*PIXEL_WIDTH-1:0]      rd_word;

  assign wr_vld = (level <= WR_MAX);
  assign rd_vld = (level >= RD_MIN);
  assign wr_en  = wr_req & wr_vld;
  assign rd_en  = rd_req & rd_vld;
  assign ram_we = wr_en & ~flush & ~rst;

  // Occupancy after this cycle's accepted operations.
  always_comb begin
    level_next = level;
    if (wr_en) level_next = level_next + WR_INC;
    if (rd_en) level_next = level_next - RD_DEC;
  end

  // Split the write word into lanes at wrapping addresses.
  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    for (int k = 0; k < WR_LANES; k++) begin
      wr_addr[k] = wr_ptr + ADDR_WIDTH'(k);
      wr_data[k] = PIXEL_WIDTH'(lane_extract(
        MAX_WORD_BITS'(din), WR_LANES, PIXEL_WIDTH, k));
    end
  end

  // Gather read lanes, oldest pixel into the MSBs.
  always_comb begin
    rd_addr = '0;
    rd_word = '0;
    for (int k = 0; k < RD_LANES; k++) begin
      rd_addr[k] = rd_ptr + ADDR_WIDTH'(k);
      rd_word[(RD_LANES-1-k)*PIXEL_WIDTH +: PIXEL_WIDTH] = rd_data[k];
    end
  end

  pixel_lane_ram #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .WR_LANES    (WR_LANES),
    .RD_LANES    (RD_LANES),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Pointers and occupancy; flush drops any concurrent access.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + WR_STEP;
      if (rd_en) rd_ptr <= rd_ptr + RD_STEP;
      level <= level_next;
    end
  end

  // Output register; flush keeps dout but kills the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else if (flush) begin
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= rd_en;
      if (rd_en) dout <= rd_word;
    end
  end

endmodule

// File: tb/tb_pixel_gearbox_fifo.sv
// Self-checking bench for pixel_gearbox_fifo (defaults).
// Reference model is a pixel queue.
module tb_pixel_gearbox_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        wr_req;
  logic        wr_vld;
  logic        rd_req;
  logic        rd_vld;
  logic [23:0] dout;
  logic        dout_vld;
  logic        flush;
  logic [4:0]  level;

  int checks = 0;
  int errors = 0;

  logic [7:0]  q[$];
  logic [23:0] m_dout;
  logic        m_vld;
  logic        m_wen;

  pixel_gearbox_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .wr_req   (wr_req),
    .wr_vld   (wr_vld),
    .rd_req   (rd_req),
    .rd_vld   (rd_vld),
    .dout     (dout),
    .dout_vld (dout_vld),
    .flush    (flush),
    .level    (level)
  );

  always #5 clk = ~clk;

  // Advance the queue model with the current inputs, then clock.
  task automatic cycle();
    int sz;
    bit ren;
    sz    = q.size();
    m_wen = 1'b0;
    if (rst) begin
      q.delete();
      m_dout = '0;
      m_vld  = 1'b0;
    end else if (flush) begin
      q.delete();
      m_vld = 1'b0;
    end else begin
      m_wen = wr_req && (sz <= 12);
      ren   = rd_req && (sz >= 3);
      m_vld = ren;
      if (ren) begin
        m_dout = {q[0], q[1], q[2]};
        repeat (3) void'(q.pop_front());
      end
      if (m_wen)
        for (int k = 0; k < 4; k++) q.push_back(din[31-8*k -: 8]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; wr_req = 0; rd_req = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rst    = 1;
      din    = $urandom;
      wr_req = 1'($urandom);
      rd_req = 1'($urandom);
      flush  = 1'($urandom);
      cycle();
    end
    idle();
    checks++;
    if (level !== 5'd0) begin
      errors++; $display("FAIL reset_level got %0d want 0", level);
    end
    checks++;
    if (wr_vld !== 1'b1) begin
      errors++; $display("FAIL reset_wr_vld got %b want 1", wr_vld);
    end
    checks++;
    if (rd_vld !== 1'b0) begin
      errors++; $display("FAIL reset_rd_vld got %b want 0", rd_vld);
    end
    checks++;
    if (dout !== 24'h0) begin
      errors++; $display("FAIL reset_dout got %h want 0", dout);
    end
    checks++;
    if (dout_vld !== 1'b0) begin
      errors++; $display("FAIL reset_dout_vld got %b want 0", dout_vld);
    end
  endtask

  task automatic test_basic_read();
    do_reset();
    din = 32'h11223344; wr_req = 1;
    cycle();
    wr_req = 0;
    checks++;
    if (level !== 5'd4 || rd_vld !== 1'b1) begin
      errors++;
      $display("FAIL basic_wr level=%0d rd_vld=%b want 4/1", level, rd_vld);
    end
    rd_req = 1;
    cycle();
    rd_req = 0;
    checks++;
    if (dout !== 24'h112233 || dout_vld !== 1'b1 || level !== 5'd1) begin
      errors++;
      $display("FAIL basic_rd dout=%h vld=%b level=%0d want 112233/1/1",
               dout, dout_vld, level);
    end
    cycle();
    checks++;
    if (dout_vld !== 1'b0 || dout !== 24'h112233) begin
      errors++;
      $display("FAIL basic_pulse vld=%b dout=%h want 0/112233",
               dout_vld, dout);
    end
  endtask

  task automatic test_full();
    do_reset();
    wr_req = 1;
    for (int i = 0; i < 3; i++) begin
      din = $urandom;
      cycle();
    end
    checks++;
    if (level !== 5'd12 || wr_vld !== 1'b1) begin
      errors++;
      $display("FAIL full_12 level=%0d wr_vld=%b want 12/1", level, wr_vld);
    end
    din = $urandom;
    cycle();
    checks++;
    if (level !== 5'd16 || wr_vld !== 1'b0) begin
      errors++;
      $display("FAIL full_16 level=%0d wr_vld=%b want 16/0", level, wr_vld);
    end
    din = $urandom;
    cycle();
    wr_req = 0;
    checks++;
    if (level !== 5'd16) begin
      errors++; $display("FAIL full_ignore level=%0d want 16", level);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    din = 32'hAABBCCDD; wr_req = 1;
    cycle();
    din = 32'h01020304; rd_req = 1;
    cycle();
    wr_req = 0;
    checks++;
    if (level !== 5'd5 || dout !== 24'hAABBCC) begin
      errors++;
      $display("FAIL simul level=%0d dout=%h want 5/aabbcc", level, dout);
    end
    cycle();
    rd_req = 0;
    checks++;
    if (dout !== 24'hDD0102 || level !== 5'd2) begin
      errors++;
      $display("FAIL simul_next dout=%h level=%0d want dd0102/2",
               dout, level);
    end
  endtask

  task automatic test_wrap();
    int widx, ntrip, cyc;
    logic [23:0] exp;
    do_reset();
    widx = 0; ntrip = 0; cyc = 0;
    while (ntrip < 32 && cyc < 400) begin
      wr_req = (widx < 24);
      din = {8'(4*widx), 8'(4*widx+1), 8'(4*widx+2), 8'(4*widx+3)};
      rd_req = 1;
      cycle();
      if (m_wen) widx++;
      if (dout_vld) begin
        exp = {8'(3*ntrip), 8'(3*ntrip+1), 8'(3*ntrip+2)};
        checks++;
        if (dout !== exp) begin
          errors++;
          $display("FAIL wrap_trip%0d got %h want %h", ntrip, dout, exp);
        end
        ntrip++;
      end
      cyc++;
    end
    idle();
    checks++;
    if (ntrip != 32 || level !== 5'd0) begin
      errors++;
      $display("FAIL wrap_count trips=%0d level=%0d want 32/0",
               ntrip, level);
    end
  endtask

  task automatic test_flush();
    logic [23:0] held;
    do_reset();
    wr_req = 1;
    for (int i = 0; i < 4; i++) begin
      din = $urandom;
      cycle();
    end
    wr_req = 0; rd_req = 1;
    repeat (3) cycle();
    rd_req = 0;
    checks++;
    if (level !== 5'd7) begin
      errors++; $display("FAIL flush_pre level=%0d want 7", level);
    end
    held = m_dout;
    flush = 1; wr_req = 1; din = 32'h55667788;
    cycle();
    flush = 0; wr_req = 0;
    checks++;
    if (level !== 5'd0 || rd_vld !== 1'b0 || dout !== held
        || dout_vld !== 1'b0) begin
      errors++;
      $display("FAIL flush level=%0d rd_vld=%b dout=%h vld=%b want 0/0/%h/0",
               level, rd_vld, dout, dout_vld, held);
    end
    din = 32'hCAFEBABE; wr_req = 1;
    cycle();
    wr_req = 0; rd_req = 1;
    cycle();
    rd_req = 0;
    checks++;
    if (dout !== 24'hCAFEBA || level !== 5'd1) begin
      errors++;
      $display("FAIL flush_after dout=%h level=%0d want cafeba/1",
               dout, level);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(99) == 0);
      flush  = ($urandom_range(39) == 0);
      wr_req = ($urandom_range(99) < 60);
      rd_req = ($urandom_range(99) < 55);
      din    = $urandom;
      cycle();
      checks++;
      if (level !== 5'(q.size()) || wr_vld !== (q.size() <= 12)
          || rd_vld !== (q.size() >= 3)) begin
        errors++;
        $display("FAIL rand_level[%0d] level=%0d wv=%b rv=%b want %0d",
                 i, level, wr_vld, rd_vld, q.size());
      end
      checks++;
      if (dout_vld !== m_vld || dout !== m_dout) begin
        errors++;
        $display("FAIL rand_dout[%0d] dout=%h vld=%b want %h/%b",
                 i, dout, dout_vld, m_dout, m_vld);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    din = '0;
    m_dout = '0;
    m_vld = 1'b0;
    m_wen = 1'b0;
    test_reset();
    test_basic_read();
    test_full();
    test_simultaneous();
    test_wrap();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_gearbox_fifo.md
# pixel_gearbox_fifo

Parametrised pixel width-converting FIFO. It accepts WR_LANES packed pixels per write and delivers RD_LANES pixels per read, for example 32-bit words in and RGB triplets out. It sits between the bus-side word interface and the pixel-processing datapath of the steganography pipeline. Unlike the previous generation, it supports simultaneous read and write, arbitrary lane counts, a flush, and an occupancy output.

## Interface
Parameters:
- PIXEL_WIDTH, 8: bits per pixel.
- WR_LANES, 4: pixels per write word.
- RD_LANES, 3: pixels per read.
- ADDR_WIDTH, 4: log2 of depth; DEPTH = 1 << ADDR_WIDTH pixels. Must satisfy DEPTH >= WR_LANES + RD_LANES.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- din  in  WR_LANES*PIXEL_WIDTH  write word; lane 0 (first pixel) in the MSBs.
- wr_req  in  1  write request.
- wr_vld  out  1  space for a full word is available.
- rd_req  in  1  read request.
- rd_vld  out  1  at least RD_LANES pixels are stored.
- dout  out  RD_LANES*PIXEL_WIDTH  registered read data; lane 0 (oldest pixel) in the MSBs.
- dout_vld  out  1  one-cycle pulse: dout was updated this cycle.
- flush  in  1  synchronous clear of contents.
- level  out  ADDR_WIDTH+1  number of stored pixels, 0..DEPTH.

## Operation
- wr_vld = (level <= DEPTH - WR_LANES).
- rd_vld = (level >= RD_LANES).
- wr_en = wr_req & wr_vld. rd_en = rd_req & rd_vld. A request without its valid is ignored: no state change, no error.
- On wr_en, lane k of din is written to mem[wr_ptr + k] for k = 0..WR_LANES-1. wr_ptr advances by WR_LANES.
- On rd_en, dout lane k is loaded from mem[rd_ptr + k]. rd_ptr advances by RD_LANES. dout_vld is 1 in the following cycle.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH. Lane addresses also wrap, so a word may straddle the end of the array.
- Simultaneous wr_en and rd_en are both performed. level_next = level + WR_LANES*wr_en - RD_LANES*rd_en.
- The read slots never overlap the write slots in the same cycle, because the wr_vld and rd_vld bounds together with DEPTH >= WR_LANES + RD_LANES guarantee it.
- flush: level, rd_ptr and wr_ptr are cleared. Any concurrent write or read is dropped. dout holds its value, and dout_vld is 0 in the next cycle.
- Priority: rst > flush > (wr_en, rd_en).
- Memory contents are not reset. Stale data is unreachable because reads are gated by level.

## Timing
- Reset values: level = 0, wr_vld = 1, rd_vld = 0, dout = 0, dout_vld = 0, pointers = 0.
- wr_vld, rd_vld and level are registered-state decodes. They reflect all accepted operations one cycle after the accepting edge.
- Write to read availability: a write accepted at edge N makes rd_vld rise after edge N if level reaches RD_LANES. A read can then be accepted at edge N+1.
- Read latency is 1: a read accepted at edge N produces dout and dout_vld = 1 after edge N, held until the next rd_en.
- Full and empty bounds are checked against the current level only. There is no same-cycle pass-through and no bypass.
- Reset mid-stream takes effect at the next edge. All outputs take their reset values, and in-flight reads are lost.
- Sustained throughput is one write and one read per cycle. level stays bounded in steady state only if the upstream rate is throttled by wr_vld.

## Structure
- Shared package pixel_fifo_pkg holds:
  - default PIXEL_WIDTH;
  - a lane-extract function (word, lane) -> pixel with MSB-first ordering;
  - the DEPTH >= WR_LANES + RD_LANES check, used as an elaboration assertion.
- One sub-module, pixel_lane_ram: a register array with WR_LANES write ports and RD_LANES read ports (combinational addresses, no reset).
- The top level holds pointers, level, handshake decode and the dout register.

## Test plan
All scenarios use default parameters (DEPTH = 16).
- Reset: hold rst = 1 for 2 cycles with random inputs -> level = 0, wr_vld = 1, rd_vld = 0, dout = 0, dout_vld = 0.
- Basic read: write 0x11223344, then read one cycle later:
  - after the write, level = 4 and rd_vld = 1;
  - after the read, dout = 0x112233, dout_vld pulses for one cycle and level = 1.
- Full: 3 writes -> level = 12, wr_vld = 1. 4th write -> level = 16, wr_vld = 0. A 5th wr_req is ignored (level stays 16).
- Simultaneous: at level 4 holding 0xAABBCCDD, write 0x01020304 and read in the same cycle -> level = 5, dout = 0xAABBCC. A subsequent read gives dout = 0xDD0102.
- Wrap: stream 24 words of incrementing pixels 0x00..0x5F with continuous reads -> 32 triplets out in exact input order across pointer wrap, with no dropped or duplicated pixel.
- Flush: at level 7, assert flush together with wr_req -> level = 0, rd_vld = 0, dout unchanged, write dropped. The next write is read back correctly from address 0.
